ppu_bus_arb: RTL and testbench
==============================

# ppu_bus_arb

Arbiter and sequencer for the PPU's 14-bit memory-map bus (CHR + nametable VRAM). It shares the single-ported, 1-cycle-read-latency memory map between the background/sprite fetch engine and the CPU PPUDATA/PPUADDR port. It also owns the CPU-side VRAM address register, the two-write address latch, the auto-increment and the delayed PPUDATA read buffer. It sits between the PPU register file and the memory map.

## Interface
- MAX_WAIT, 8: cycles a pending CPU access may be denied before it is forced onto the bus (guard builds only).
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  1  renderer fetch request.
- rd_addr  in  14  renderer fetch address.
- rd_gnt  out  1  renderer access issued this cycle.
- rd_valid  out  1  renderer read data valid (cycle after grant).
- rd_data  out  8  renderer read data.
- cpu_addr_wr  in  1  PPUADDR write strobe.
- cpu_stat_rd  in  1  PPUSTATUS read strobe; clears the write latch.
- cpu_wr  in  1  PPUDATA write strobe.
- cpu_rd  in  1  PPUDATA read strobe.
- cpu_wdata  in  8  CPU write data (PPUADDR or PPUDATA).
- cpu_inc32  in  1  increment select: 1 = +32, 0 = +1.
- cpu_rdata  out  8  read buffer contents.
- cpu_busy  out  1  CPU access pending or in flight.
- cpu_ovf  out  1  sticky: PPUDATA strobe dropped while busy.
- mem_addr  out  14  to memory map.
- mem_rw  out  1  1 = read, 0 = write.
- mem_wdata  out  8  to memory map.
- mem_rdata  in  8  from memory map, valid one cycle after address.

## Operation
- **v register (14 b) and w latch (1 b).**
  - cpu_addr_wr with w=0: v[13:8] ← cpu_wdata[5:0], w ← 1.
  - cpu_addr_wr with w=1: v[7:0] ← cpu_wdata, w ← 0.
  - cpu_stat_rd: w ← 0, applied after any same-cycle address write.
- **PPUDATA strobe accepted** when cpu_busy=0.
  - pend_addr ← v; v ← v + (cpu_inc32 ? 32 : 1), modulo 2^14.
  - Write: pend_op = WR, pend_data ← cpu_wdata.
  - Read: pend_op = RD. cpu_rdata keeps showing the old buffer, so the CPU gets stale data and the buffer is refilled.
- cpu_rd and cpu_wr together: treated as a write; the read is ignored.
- A PPUDATA strobe while cpu_busy=1 is dropped: v is unchanged and cpu_ovf ← 1.
- cpu_addr_wr in the same cycle as an accepted PPUDATA strobe: the data access uses the old v, and the address write overrides the increment.
- **Arbiter states.**
  - IDLE: no CPU op pending.
  - PEND: CPU op waiting for the bus.
  - FILL: CPU read issued, capturing data.
- **Grant rules, per cycle.**
  - The renderer has priority: if rd_req=1 (and the guard is not firing), rd_gnt=1 and mem_addr=rd_addr, mem_rw=1.
  - Otherwise, in PEND: issue the CPU op with mem_addr=pend_addr, mem_rw=(pend_op==RD), mem_wdata=pend_data.
    - After a write: → IDLE.
    - After a read: → FILL.
  - FILL: buffer ← mem_rdata → IDLE. A renderer grant may be issued in the same cycle.
- **Idle bus:** mem_addr=0, mem_rw=1, mem_wdata=0. The renderer is never granted a write.
- A 1-b owner register records who issued the previous read, and that owner steers mem_rdata to rd_data or to the buffer.

## Timing
- Grant and mem_* are combinational from the current state and rd_req.
- Renderer: grant in cycle N → rd_valid=1, rd_data=mem_rdata in N+1. Back-to-back grants give a 1/cycle throughput.
- CPU write: strobe in cycle S → earliest issue S+1 → cpu_busy low from the issue cycle +1.
- CPU read: strobe in S → earliest issue S+1, FILL in S+2, buffer updated at the end of S+2, cpu_busy low in S+3.
- cpu_busy=1 from S+1 through the last FILL/issue cycle.
- **Reset** (asynchronous, any state, including mid-FILL):
  - pend_op and state → IDLE; v, w, buffer, pend_* → 0.
  - Outputs: cpu_rdata=0, cpu_busy=0, cpu_ovf=0, rd_valid=0, rd_data=0, rd_gnt=0, mem_addr=0, mem_rw=1, mem_wdata=0.
  - An in-flight read is discarded.
- rd_valid and rd_data are registered. cpu_rdata is a register.

## Configuration
- `PPU_BUS_STARVE_GUARD_EN` defined:
  - A wait counter (width $clog2(MAX_WAIT+1)) increments in every PEND cycle where the CPU is denied.
  - When it equals MAX_WAIT, the CPU op is issued that cycle, rd_gnt=0 despite rd_req, and the counter clears. The counter also clears on CPU issue and on reset.
- Undefined: strict renderer priority; a CPU op waits indefinitely while rd_req=1. MAX_WAIT is unused.

## Structure
- Package ppu_bus_pkg:
  - PPU_ADDR_W=14.
  - typedef enum {OP_NONE, OP_RD, OP_WR} ppu_op_t.
  - Arbiter state enum.
  - INC1=1, INC32=32.
- Sub-module ppu_vaddr holds the v/w latch, PPUADDR decode and the increment logic.

## Test plan
- **PPUADDR + increment:** addr writes 0x21, 0x08, then cpu_wr 0x55 with inc32=0 → mem write at 0x2108 data 0x55, then v=0x2109. With inc32=1 from 0x2108 → v=0x2128.
- **Delayed read:** with VRAM[0x2000]=0xAA and [0x2001]=0xBB, set v=0x2000 and read twice. First cpu_rdata = old buffer (0 after reset). After the refill, the buffer holds 0xAA, and the second read returns 0xAA.
- **Priority/starvation:** rd_req held high, CPU write pending. Without the macro, no CPU issue in 100 cycles. With the macro and MAX_WAIT=8, the CPU is issued on the 9th pending cycle with rd_gnt=0 that cycle.
- **Wrap and latch reset:** v=0x3FFF with inc32=0 → v=0x0000 after access. cpu_stat_rd between two addr writes → the second write goes to the high byte.
- **Overflow:** cpu_wr while busy → dropped, cpu_ovf=1, v unchanged, memory unchanged.
- **Reset mid-FILL:** assert rst during FILL → all outputs hold their reset values immediately and the buffer stays 0 after release.

Source files
------------

// File: rtl/ppu_bus_pkg.sv
// ----------------------------------------------------------------------------
// ppu_bus_pkg
// Shared types and constants for the PPU memory-map bus arbiter.
//   PPU_ADDR_W   : width of the PPU memory-map address (14 bits, 16 KiB)
//   INC1/INC32   : VRAM address auto-increment steps (across / down)
//   ppu_op_t     : pending CPU operation kind
//   arb_state_t  : arbiter sequencing states
//   owner_t      : who issued the read whose data is on mem_rdata
// ----------------------------------------------------------------------------
package ppu_bus_pkg;

   localparam int PPU_ADDR_W = 14;
   localparam int INC1       = 1;
   localparam int INC32      = 32;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_RD   = 2'd1,
      OP_WR   = 2'd2
   } ppu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no CPU op pending
      ST_PEND = 2'd1,   // CPU op waiting for the bus
      ST_FILL = 2'd2    // CPU read issued last cycle, data arriving now
   } arb_state_t;

   typedef enum logic {
      OWN_RD  = 1'b0,
      OWN_CPU = 1'b1
   } owner_t;

   // Next VRAM address after a PPUDATA access; wraps modulo 2^14.
   function automatic logic [PPU_ADDR_W-1:0] vaddr_step(
      input logic [PPU_ADDR_W-1:0] v,
      input logic                  inc32
   );
      return v + (inc32 ? PPU_ADDR_W'(INC32) : PPU_ADDR_W'(INC1));
   endfunction

endpackage

// File: rtl/ppu_vaddr.sv
// ----------------------------------------------------------------------------
// ppu_vaddr
// CPU-side VRAM address register (v) with the PPUADDR two-write latch (w).
//   clk, rst   : clock, asynchronous active-high reset
//   addr_wr    : PPUADDR write strobe (first write = high 6 bits, second = low)
//   stat_rd    : PPUSTATUS read strobe, clears w after any same-cycle write
//   wdata      : CPU write data
//   step       : a PPUDATA access was accepted this cycle; advance v
//   inc32      : step size select, 1 = +32, 0 = +1
//   v          : current VRAM address
// ----------------------------------------------------------------------------
module ppu_vaddr
   import ppu_bus_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  addr_wr,
   input  logic                  stat_rd,
   input  logic [7:0]            wdata,
   input  logic                  step,
   input  logic                  inc32,
   output logic [PPU_ADDR_W-1:0] v
);

   logic w;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; the later assignment to w below wins within the block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
         w <= 1'b0;
      end else begin
         // An address write overrides the increment of a same-cycle access;
         // the access itself has already captured the old v.
         if (addr_wr) begin
            if (!w) begin
               v[13:8] <= wdata[5:0];
               w       <= 1'b1;
            end else begin
               v[7:0]  <= wdata;
               w       <= 1'b0;
            end
         end else if (step) begin
            v <= vaddr_step(v, inc32);
         end
         if (stat_rd) begin
            w <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ppu_bus_arb.sv
// ----------------------------------------------------------------------------
// ppu_bus_arb
// Arbiter/sequencer for the PPU 14-bit memory-map bus. Shares the single-port,
// 1-cycle-read-latency memory between the renderer fetch engine (priority)
// and the CPU PPUDATA port, and owns the VRAM address register, the PPUADDR
// write latch, auto-increment and the delayed PPUDATA read buffer.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   rd_req/rd_addr        : renderer fetch request and address
//   rd_gnt                : renderer access issued this cycle (combinational)
//   rd_valid/rd_data      : renderer read data, the cycle after the grant
//   cpu_addr_wr           : PPUADDR write strobe
//   cpu_stat_rd           : PPUSTATUS read strobe (clears write latch)
//   cpu_wr/cpu_rd         : PPUDATA write/read strobes
//   cpu_wdata, cpu_inc32  : CPU write data, increment select (1 = +32)
//   cpu_rdata             : PPUDATA read buffer
//   cpu_busy              : CPU access pending or in flight
//   cpu_ovf               : sticky, PPUDATA strobe dropped while busy
//   mem_addr/rw/wdata     : to memory map (rw 1 = read)
//   mem_rdata             : from memory map, valid one cycle after address
//
// Build option: define PPU_BUS_STARVE_GUARD_EN to force a pending CPU access
// onto the bus after MAX_WAIT denied cycles. Without it the renderer has
// strict priority and MAX_WAIT is unused.
// ----------------------------------------------------------------------------
module ppu_bus_arb
   import ppu_bus_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_req,
   input  logic [PPU_ADDR_W-1:0] rd_addr,
   output logic                  rd_gnt,
   output logic                  rd_valid,
   output logic [7:0]            rd_data,
   input  logic                  cpu_addr_wr,
   input  logic                  cpu_stat_rd,
   input  logic                  cpu_wr,
   input  logic                  cpu_rd,
   input  logic [7:0]            cpu_wdata,
   input  logic                  cpu_inc32,
   output logic [7:0]            cpu_rdata,
   output logic                  cpu_busy,
   output logic                  cpu_ovf,
   output logic [PPU_ADDR_W-1:0] mem_addr,
   output logic                  mem_rw,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata
);

   arb_state_t            state;
   ppu_op_t               pend_op;
   logic [PPU_ADDR_W-1:0] pend_addr;
   logic [7:0]            pend_data;
   owner_t                owner;
   logic [PPU_ADDR_W-1:0] v;

   logic any_strobe;
   logic accept;
   logic cpu_issue;
   logic guard_fire;

   assign any_strobe = cpu_wr | cpu_rd;
   assign cpu_busy   = (state != ST_IDLE);
   assign accept     = any_strobe & ~cpu_busy;

   ppu_vaddr u_vaddr (
      .clk     (clk),
      .rst     (rst),
      .addr_wr (cpu_addr_wr),
      .stat_rd (cpu_stat_rd),
      .wdata   (cpu_wdata),
      .step    (accept),
      .inc32   (cpu_inc32),
      .v       (v)
   );

`ifdef PPU_BUS_STARVE_GUARD_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   logic [WAIT_W-1:0] wait_cnt;

   assign guard_fire = (state == ST_PEND) && (wait_cnt == WAIT_W'(MAX_WAIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (cpu_issue) begin
         wait_cnt <= '0;
      end else if ((state == ST_PEND) && rd_gnt) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   assign guard_fire = 1'b0;
`endif

   // Grants are gated by rst so the bus shows its idle values the instant
   // reset asserts, even while rd_req is held.
   assign rd_gnt    = rd_req & ~guard_fire & ~rst;
   assign cpu_issue = (state == ST_PEND) & ~rd_gnt & ~rst;

   // NOTE: every output of this block gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      mem_addr  = '0;
      mem_rw    = 1'b1;
      mem_wdata = '0;
      if (rd_gnt) begin
         mem_addr = rd_addr;
      end else if (cpu_issue) begin
         mem_addr  = pend_addr;
         mem_rw    = (pend_op == OP_RD);
         mem_wdata = pend_data;
      end
   end

   // Read data belongs to whoever issued the previous read; only renderer
   // reads are shown on rd_data.
   assign rd_data = (rd_valid && (owner == OWN_RD)) ? mem_rdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pend_op   <= OP_NONE;
         pend_addr <= '0;
         pend_data <= '0;
         owner     <= OWN_RD;
         rd_valid  <= 1'b0;
         cpu_rdata <= '0;
         cpu_ovf   <= 1'b0;
      end else begin
         rd_valid <= rd_gnt;

         if (rd_gnt) begin
            owner <= OWN_RD;
         end else if (cpu_issue && (pend_op == OP_RD)) begin
            owner <= OWN_CPU;
         end

         if (any_strobe && cpu_busy) begin
            cpu_ovf <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state     <= ST_PEND;
                  pend_addr <= v;
                  // A simultaneous read and write is taken as a write.
                  if (cpu_wr) begin
                     pend_op   <= OP_WR;
                     pend_data <= cpu_wdata;
                  end else begin
                     pend_op   <= OP_RD;
                  end
               end
            end
            ST_PEND: begin
               if (cpu_issue) begin
                  if (pend_op == OP_RD) begin
                     state <= ST_FILL;
                  end else begin
                     state   <= ST_IDLE;
                     pend_op <= OP_NONE;
                  end
               end
            end
            ST_FILL: begin
               // owner still reflects the CPU read issued last cycle even if
               // the renderer is granted in this same cycle.
               if (owner == OWN_CPU) begin
                  cpu_rdata <= mem_rdata;
               end
               state   <= ST_IDLE;
               pend_op <= OP_NONE;
            end
            default: begin
               state   <= ST_IDLE;
               pend_op <= OP_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ppu_bus_arb.sv
// ----------------------------------------------------------------------------
// tb_ppu_bus_arb
// Self-checking bench for ppu_bus_arb: a table of renderer fetch vectors plus
// directed sequences for PPUADDR/increment, delayed reads, wrap, latch clear,
// overflow, renderer priority / starvation guard and reset during FILL.
// Build with +define+PPU_BUS_STARVE_GUARD_EN to check the guard build.
// ----------------------------------------------------------------------------
module tb_ppu_bus_arb;

   logic        clk;
   logic        rst;
   logic        rd_req;
   logic [13:0] rd_addr;
   logic        rd_gnt;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        cpu_addr_wr;
   logic        cpu_stat_rd;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [7:0]  cpu_wdata;
   logic        cpu_inc32;
   logic [7:0]  cpu_rdata;
   logic        cpu_busy;
   logic        cpu_ovf;
   logic [13:0] mem_addr;
   logic        mem_rw;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] vram [0:16383];

   ppu_bus_arb #(.MAX_WAIT(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_gnt      (rd_gnt),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .cpu_addr_wr (cpu_addr_wr),
      .cpu_stat_rd (cpu_stat_rd),
      .cpu_wr      (cpu_wr),
      .cpu_rd      (cpu_rd),
      .cpu_wdata   (cpu_wdata),
      .cpu_inc32   (cpu_inc32),
      .cpu_rdata   (cpu_rdata),
      .cpu_busy    (cpu_busy),
      .cpu_ovf     (cpu_ovf),
      .mem_addr    (mem_addr),
      .mem_rw      (mem_rw),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory map model: synchronous write, one-cycle read latency.
   initial mem_rdata = 8'h00;
   always @(posedge clk) begin
      if (!mem_rw) vram[mem_addr] <= mem_wdata;
      mem_rdata <= vram[mem_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic addr_wr(input logic [7:0] d);
      cpu_addr_wr = 1'b1;
      cpu_wdata   = d;
      @(negedge clk);
      cpu_addr_wr = 1'b0;
      cpu_wdata   = 8'h00;
   endtask

   task automatic stat_rd();
      cpu_stat_rd = 1'b1;
      @(negedge clk);
      cpu_stat_rd = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] d, input logic inc, input logic [13:0] exp_addr,
                            input string tag);
      cpu_wr    = 1'b1;
      cpu_wdata = d;
      cpu_inc32 = inc;
      @(negedge clk);
      cpu_wr    = 1'b0;
      cpu_wdata = 8'h00;
      cpu_inc32 = 1'b0;
      #1;
      check({tag, " issue rw"},    mem_rw,    1'b0);
      check({tag, " issue addr"},  mem_addr,  exp_addr);
      check({tag, " issue wdata"}, mem_wdata, d);
      check({tag, " busy issue"},  cpu_busy,  1'b1);
      @(negedge clk);
      #1;
      check({tag, " busy after"},  cpu_busy,  1'b0);
      check({tag, " mem content"}, vram[exp_addr], d);
   endtask

   task automatic cpu_read(input logic [13:0] exp_addr, input logic [7:0] old_buf,
                           input logic [7:0] new_buf, input string tag);
      cpu_rd = 1'b1;
      #1;
      check({tag, " rdata strobe"}, cpu_rdata, old_buf);
      @(negedge clk);
      cpu_rd = 1'b0;
      #1;
      check({tag, " issue rw"},    mem_rw,    1'b1);
      check({tag, " issue addr"},  mem_addr,  exp_addr);
      check({tag, " busy issue"},  cpu_busy,  1'b1);
      @(negedge clk);
      #1;
      check({tag, " busy fill"},   cpu_busy,  1'b1);
      check({tag, " rdata fill"},  cpu_rdata, old_buf);
      @(negedge clk);
      #1;
      check({tag, " busy after"},  cpu_busy,  1'b0);
      check({tag, " rdata new"},   cpu_rdata, new_buf);
   endtask

   typedef struct {
      logic        req;
      logic [13:0] addr;
      logic        gnt;
      logic [13:0] maddr;
      logic        rw;
      logic        valid;
      logic [7:0]  data;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int first_issue;
      logic gnt_at_issue;

      for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
      vram[14'h0000] = 8'h3C;
      vram[14'h0123] = 8'h5A;
      vram[14'h1FFF] = 8'hC3;
      vram[14'h2000] = 8'hAA;
      vram[14'h2001] = 8'hBB;
      vram[14'h3FFF] = 8'h7E;

      // Renderer fetches: drive req/addr, check grant and bus this cycle,
      // and valid/data belonging to the previous vector's grant.
      vecs[0] = '{1'b1, 14'h0123, 1'b1, 14'h0123, 1'b1, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 14'h1FFF, 1'b1, 14'h1FFF, 1'b1, 1'b1, 8'h5A};
      vecs[2] = '{1'b0, 14'h2222, 1'b0, 14'h0000, 1'b1, 1'b1, 8'hC3};
      vecs[3] = '{1'b1, 14'h3FFF, 1'b1, 14'h3FFF, 1'b1, 1'b0, 8'h00};
      vecs[4] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 1'b1, 8'h7E};
      vecs[5] = '{1'b0, 14'h0000, 1'b0, 14'h0000, 1'b1, 1'b0, 8'h00};

      rst = 1'b1; rd_req = 1'b1; rd_addr = 14'h0123;
      cpu_addr_wr = 1'b0; cpu_stat_rd = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
      cpu_wdata = 8'h00; cpu_inc32 = 1'b0;
      #2;
      check("reset cpu_rdata", cpu_rdata, 8'h00);
      check("reset cpu_busy",  cpu_busy,  1'b0);
      check("reset cpu_ovf",   cpu_ovf,   1'b0);
      check("reset rd_valid",  rd_valid,  1'b0);
      check("reset rd_data",   rd_data,   8'h00);
      check("reset rd_gnt",    rd_gnt,    1'b0);
      check("reset mem_addr",  mem_addr,  14'h0000);
      check("reset mem_rw",    mem_rw,    1'b1);
      check("reset mem_wdata", mem_wdata, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; rd_req = 1'b0; rd_addr = 14'h0000;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         rd_req  = vecs[i].req;
         rd_addr = vecs[i].addr;
         #1;
         check($sformatf("vec%0d rd_gnt", i),   rd_gnt,   vecs[i].gnt);
         check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].maddr);
         check($sformatf("vec%0d mem_rw", i),   mem_rw,   vecs[i].rw);
         check($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].valid);
         check($sformatf("vec%0d rd_data", i),  rd_data,  vecs[i].data);
         @(negedge clk);
      end

      // Delayed read: first read returns the reset buffer, second returns 0xAA.
      addr_wr(8'h20);
      addr_wr(8'h00);
      cpu_read(14'h2000, 8'h00, 8'hAA, "dread1");
      cpu_read(14'h2001, 8'hAA, 8'hBB, "dread2");

      // PPUADDR + increment.
      addr_wr(8'h21);
      addr_wr(8'h08);
      cpu_write(8'h55, 1'b0, 14'h2108, "wr inc1");
      cpu_read(14'h2109, 8'hBB, 8'h00, "rd after inc1");
      addr_wr(8'h21);
      addr_wr(8'h08);
      cpu_write(8'h66, 1'b1, 14'h2108, "wr inc32");
      cpu_write(8'h77, 1'b0, 14'h2128, "wr after inc32");

      // Wrap at the top of the address space.
      addr_wr(8'h3F);
      addr_wr(8'hFF);
      cpu_write(8'h12, 1'b0, 14'h3FFF, "wr 3fff");
      cpu_read(14'h0000, 8'h00, 8'h3C, "rd wrap");

      // Status read between address writes clears the latch.
      addr_wr(8'h05);
      stat_rd();
      addr_wr(8'h06);
      addr_wr(8'h40);
      cpu_write(8'h21, 1'b0, 14'h0640, "wr latch clr");

      // Overflow: second strobe while the first write is still pending.
      addr_wr(8'h10);
      addr_wr(8'h00);
      rd_req = 1'b1; rd_addr = 14'h0123;
      cpu_wr = 1'b1; cpu_wdata = 8'h99;
      @(negedge clk);
      cpu_wdata = 8'hEE;
      #1;
      check("ovf busy pend",     cpu_busy, 1'b1);
      check("ovf renderer wins", mem_rw,   1'b1);
      @(negedge clk);
      cpu_wr = 1'b0; cpu_wdata = 8'h00; rd_req = 1'b0;
      #1;
      check("ovf sticky",        cpu_ovf,   1'b1);
      check("ovf issue rw",      mem_rw,    1'b0);
      check("ovf issue addr",    mem_addr,  14'h1000);
      check("ovf issue wdata",   mem_wdata, 8'h99);
      @(negedge clk);
      #1;
      check("ovf mem kept",      vram[14'h1000], 8'h99);
      cpu_write(8'h33, 1'b0, 14'h1001, "wr after ovf");
      check("ovf still set",     cpu_ovf, 1'b1);

      // Priority / starvation with rd_req held high.
      addr_wr(8'h22);
      addr_wr(8'h00);
      rd_req = 1'b1; rd_addr = 14'h0123;
      cpu_wr = 1'b1; cpu_wdata = 8'h44;
      @(negedge clk);
      cpu_wr = 1'b0; cpu_wdata = 8'h00;
      first_issue  = 0;
      gnt_at_issue = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         #1;
         if (!mem_rw && first_issue == 0) begin
            first_issue  = i;
            gnt_at_issue = rd_gnt;
         end
         @(negedge clk);
      end
`ifdef PPU_BUS_STARVE_GUARD_EN
      check("guard issue cycle", first_issue, 9);
      check("guard rd_gnt low",  gnt_at_issue, 1'b0);
      check("guard mem content", vram[14'h2200], 8'h44);
      rd_req = 1'b0;
      #1;
      check("guard idle after", cpu_busy, 1'b0);
`else
      check("strict no issue",   first_issue, 0);
      check("strict still busy", cpu_busy, 1'b1);
      rd_req = 1'b0;
      #1;
      check("strict issue rw",   mem_rw,    1'b0);
      check("strict issue addr", mem_addr,  14'h2200);
      check("strict issue data", mem_wdata, 8'h44);
`endif
      @(negedge clk);
      #1;
      check("starve busy done", cpu_busy, 1'b0);

      // Reset during FILL (renderer granted in the FILL cycle).
      addr_wr(8'h20);
      addr_wr(8'h01);
      cpu_rd = 1'b1;
      @(negedge clk);
      cpu_rd = 1'b0;
      @(negedge clk);
      rd_req = 1'b1; rd_addr = 14'h0123;
      #1;
      check("fill busy",       cpu_busy, 1'b1);
      check("fill rd_gnt",     rd_gnt,   1'b1);
      rst = 1'b1;
      #1;
      check("rstfill cpu_rdata", cpu_rdata, 8'h00);
      check("rstfill cpu_busy",  cpu_busy,  1'b0);
      check("rstfill cpu_ovf",   cpu_ovf,   1'b0);
      check("rstfill rd_valid",  rd_valid,  1'b0);
      check("rstfill rd_data",   rd_data,   8'h00);
      check("rstfill rd_gnt",    rd_gnt,    1'b0);
      check("rstfill mem_addr",  mem_addr,  14'h0000);
      check("rstfill mem_rw",    mem_rw,    1'b1);
      check("rstfill mem_wdata", mem_wdata, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; rd_req = 1'b0; rd_addr = 14'h0000;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("post rst buffer", cpu_rdata, 8'h00);
      check("post rst busy",   cpu_busy,  1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
